// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Single-port data memory responder for an RV32I load/store controller.
//   One request in flight: IDLE accepts, ACCESS touches storage, RESP
//   pulses resp_valid. resp_valid is high two cycles after the cycle in
//   which the request was accepted.
//
// Parameters
//   DEPTH_LOG2 : log2 of the number of 32-bit words in storage
//   INIT_ZERO  : 1 = storage starts cleared, 0 = contents undefined
//
// Ports
//   clk, rst_n             : clock, asynchronous active-low reset
//   req_valid / req_ready  : request handshake (ready only in IDLE)
//   req_wr                 : 1 = store, 0 = load
//   req_addr               : byte address (wraps modulo storage size)
//   req_wdata              : store data, right-justified
//   req_funct3             : RV32I width / sign code
//   resp_valid             : one-cycle completion pulse
//   resp_rdata             : extended load data (0 for stores and errors)
//   resp_err               : request rejected (qualified by resp_valid)
//
// Build option
//   DMEM_MISALIGN_TRAP_EN  : when defined, misaligned half/word accesses are
//                            rejected; otherwise the address is force-aligned.
module data_mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int INIT_ZERO  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2 + 2;
  localparam logic [31:0] INIT_WORD = (INIT_ZERO != 0) ? 32'h0000_0000 : 32'hxxxx_xxxx;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // funct3 codes outside the legal load/store set
  function automatic logic f3_illegal(input logic wr, input logic [2:0] f3);
    logic bad;
    bad = 1'b1;
    if (wr) begin
      bad = f3[2] || (f3[1:0] == 2'b11);
    end else begin
      case (f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: bad = 1'b0;
        default:                                bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

  // Full reject decision; misalignment only rejects when the trap is built in
  function automatic logic reject_fn(input logic wr, input logic [2:0] f3, input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    case (f3[1:0])
      2'b01:   mis = lane[0];
      2'b10:   mis = |lane;
      default: mis = 1'b0;
    endcase
`else
    mis = 1'b0 & (|lane);
`endif
    return f3_illegal(wr, f3) || mis;
  endfunction

  // Force-align the lane to the access width
  function automatic logic [1:0] align_lane(input logic [2:0] f3, input logic [1:0] lane);
    logic [1:0] al;
    case (f3[1:0])
      2'b01:   al = {lane[1], 1'b0};
      2'b10:   al = 2'b00;
      default: al = lane;
    endcase
    return al;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the narrow store value into every lane; byte enables pick one
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'h00_0000, b};
      3'b101:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  state_t                  state_r, state_nxt_s;
  logic                    ready_r;
  logic                    wr_r, reject_r;
  logic [2:0]              funct3_r;
  logic [1:0]              lane_r;
  logic [DEPTH_LOG2-1:0]   idx_r;
  logic                    resp_valid_r, resp_err_r;
  logic [31:0]             resp_rdata_r;

  logic [31:0] mem_r [DEPTH] = '{default: INIT_WORD};

  logic                    accept_s, in_reject_s, we_s;
  logic [1:0]              in_lane_s;
  logic [DEPTH_LOG2-1:0]   in_idx_s;
  logic [3:0]              in_be_s;
  logic [31:0]             in_data_s, rd_word_s, load_s;
  logic                    unused_addr_s;

  assign accept_s      = req_valid && (state_r == ST_IDLE);
  assign in_lane_s     = align_lane(req_funct3, req_addr[1:0]);
  assign in_reject_s   = reject_fn(req_wr, req_funct3, req_addr[1:0]);
  assign in_idx_s      = req_addr[AW-1:2];
  assign in_be_s       = store_be(req_funct3, in_lane_s);
  assign in_data_s     = store_data(req_funct3, req_wdata);
  assign we_s          = accept_s && req_wr && !in_reject_s;
  assign unused_addr_s = ^req_addr[31:AW];

  assign rd_word_s = mem_r[idx_r];
  assign load_s    = load_extract(funct3_r, lane_r, rd_word_s);

  assign req_ready  = ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) state_nxt_s = ST_ACCESS;
        else           state_nxt_s = ST_IDLE;
      end
      ST_ACCESS: state_nxt_s = ST_RESP;
      ST_RESP:   state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and registered ready (ready is 1 exactly when IDLE)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == ST_IDLE);
    end
  end

  // Latch the decoded request on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_r     <= 1'b0;
      reject_r <= 1'b0;
      funct3_r <= 3'b000;
      lane_r   <= 2'b00;
      idx_r    <= '0;
    end else if (accept_s) begin
      wr_r     <= req_wr;
      reject_r <= in_reject_s;
      funct3_r <= req_funct3;
      lane_r   <= in_lane_s;
      idx_r    <= in_idx_s;
    end
  end

  // Storage write. The store commits on the acceptance edge so the array
  // already holds it throughout ACCESS; a reset during ACCESS keeps it.
  always_ff @(posedge clk) begin
    if (we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (in_be_s[b]) mem_r[in_idx_s][8*b +: 8] <= in_data_s[8*b +: 8];
      end
    end
  end

  // Response registers: loaded at the end of ACCESS, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      resp_err_r   <= 1'b0;
    end else if (state_r == ST_ACCESS) begin
      resp_valid_r <= 1'b1;
      resp_err_r   <= reject_r;
      resp_rdata_r <= (reject_r || wr_r) ? 32'h0000_0000 : load_s;
    end else begin
      resp_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [2:0]  req_funct3 = 3'b000;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int errors = 0;
  int checks = 0;

  data_mem_responder dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  // Issue one request at a negedge and watch 8 following negedges.
  // lat = negedges after the drive point at which resp_valid was first seen.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] f3, output logic rdy, output logic [31:0] rd,
                       output logic er, output int lat, output int width);
    @(negedge clk);
    req_wr = wr; req_addr = addr; req_wdata = wd; req_funct3 = f3; req_valid = 1'b1;
    rdy = req_ready;
    lat = -1; width = 0; rd = 32'hxxxx_xxxx; er = 1'bx;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (resp_valid === 1'b1) begin
        width++;
        if (lat < 0) begin lat = i; rd = resp_rdata; er = resp_err; end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", resp_err); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_store_load();
    logic rdy, er; logic [31:0] rd; int lat, w;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rdy, rd, er, lat, w);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL sw_ready: got %b expected 1", rdy); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d expected 2", lat); end
    checks++; if (w !== 1) begin errors++; $display("FAIL sw_pulse_width: got %0d expected 1", w); end
    checks++; if ({er, rd} !== {1'b0, 32'h0}) begin errors++; $display("FAIL sw_resp: got err=%b data=%h expected err=0 data=00000000", er, rd); end
    issue(1'b0, 32'h10, 32'h0, 3'b010, rdy, rd, er, lat, w);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d expected 2", lat); end
    checks++; if ({er, rd} !== {1'b0, 32'hDEADBEEF}) begin errors++; $display("FAIL lw_data: got err=%b data=%h expected err=0 data=deadbeef", er, rd); end
    checks++; if (resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata_hold: got %h expected deadbeef", resp_rdata); end
  endtask

  task automatic test_byte_merge();
    logic rdy, er; logic [31:0] rd; int lat, w;
    issue(1'b1, 32'h11, 32'h0000_007F, 3'b000, rdy, rd, er, lat, w);
    issue(1'b0, 32'h10, 32'h0, 3'b010, rdy, rd, er, lat, w);
    checks++; if (rd !== 32'hDEAD7FEF) begin errors++; $display("FAIL sb_merge: got %h expected dead7fef", rd); end
    issue(1'b0, 32'h13, 32'h0, 3'b000, rdy, rd, er, lat, w);
    checks++; if (rd !== 32'hFFFFFFDE) begin errors++; $display("FAIL lb_sign: got %h expected ffffffde", rd); end
    issue(1'b0, 32'h13, 32'h0, 3'b100, rdy, rd, er, lat, w);
    checks++; if (rd !== 32'h000000DE) begin errors++; $display("FAIL lbu_zero: got %h expected 000000de", rd); end
    issue(1'b0, 32'h1010, 32'h0, 3'b010, rdy, rd, er, lat, w);
    checks++; if (rd !== 32'hDEAD7FEF) begin errors++; $display("FAIL addr_wrap: got %h expected dead7fef", rd); end
  endtask

  task automatic test_halfword();
    logic rdy, er; logic [31:0] rd; int lat, w;
    issue(1'b1, 32'h22, 32'h1234_8001, 3'b001, rdy, rd, er, lat, w);
    issue(1'b0, 32'h22, 32'h0, 3'b001, rdy, rd, er, lat, w);
    checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh_sign: got %h expected ffff8001", rd); end
    issue(1'b0, 32'h22, 32'h0, 3'b101, rdy, rd, er, lat, w);
    checks++; if (rd !== 32'h00008001) begin errors++; $display("FAIL lhu_zero: got %h expected 00008001", rd); end
    issue(1'b0, 32'h20, 32'h0, 3'b010, rdy, rd, er, lat, w);
    checks++; if (rd !== 32'h80010000) begin errors++; $display("FAIL sh_lane: got %h expected 80010000", rd); end
  endtask

  task automatic test_errors();
    logic rdy, er; logic [31:0] rd; int lat, w;
    issue(1'b0, 32'h10, 32'h0, 3'b011, rdy, rd, er, lat, w);
    checks++; if ({er, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL illegal_load: got err=%b data=%h expected err=1 data=00000000", er, rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL illegal_latency: got %0d expected 2", lat); end
    issue(1'b1, 32'h10, 32'hFFFF_FFFF, 3'b100, rdy, rd, er, lat, w);
    checks++; if ({er, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL illegal_store: got err=%b data=%h expected err=1 data=00000000", er, rd); end
    issue(1'b0, 32'h10, 32'h0, 3'b010, rdy, rd, er, lat, w);
    checks++; if (rd !== 32'hDEAD7FEF) begin errors++; $display("FAIL illegal_no_write: got %h expected dead7fef", rd); end
    issue(1'b0, 32'h12, 32'h0, 3'b010, rdy, rd, er, lat, w);
`ifdef DMEM_MISALIGN_TRAP_EN
    checks++; if ({er, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL misalign_lw: got err=%b data=%h expected err=1 data=00000000", er, rd); end
`else
    checks++; if ({er, rd} !== {1'b0, 32'hDEAD7FEF}) begin errors++; $display("FAIL misalign_lw: got err=%b data=%h expected err=0 data=dead7fef", er, rd); end
`endif
  endtask

  task automatic test_back_to_back();
    int accepts[$]; int pulses[$]; logic [31:0] datas[$];
    int n_acc;
    @(negedge clk);
    req_wr = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; req_valid = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      if (resp_valid === 1'b1) begin pulses.push_back(i); datas.push_back(resp_rdata); end
      if (req_valid && req_ready === 1'b1) begin
        accepts.push_back(i);
        n_acc++;
        // switch to the second request once the first is taken
        @(posedge clk); #1;
        if (n_acc == 1) begin req_addr = 32'h13; req_funct3 = 3'b100; end
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checks++; if (accepts.size() !== 2) begin errors++; $display("FAIL b2b_accept_count: got %0d expected 2", accepts.size()); end
    else begin
      checks++; if (accepts[1] !== 3) begin errors++; $display("FAIL b2b_second_accept: got cycle %0d expected 3", accepts[1]); end
    end
    checks++; if (pulses.size() !== 2) begin errors++; $display("FAIL b2b_pulse_count: got %0d expected 2", pulses.size()); end
    else begin
      checks++; if ({pulses[0], pulses[1]} !== {32'd2, 32'd5}) begin errors++; $display("FAIL b2b_pulse_cycles: got %0d,%0d expected 2,5", pulses[0], pulses[1]); end
      checks++; if ({datas[0], datas[1]} !== {32'hDEAD7FEF, 32'h000000DE}) begin errors++; $display("FAIL b2b_data: got %h,%h expected dead7fef,000000de", datas[0], datas[1]); end
    end
  endtask

  task automatic test_ready_busy();
    // ready must drop in ACCESS and RESP
    logic r1, r2;
    @(negedge clk);
    req_wr = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0; r1 = req_ready;
    @(negedge clk); r2 = req_ready;
    checks++; if ({r1, r2} !== 2'b00) begin errors++; $display("FAIL busy_ready: got %b%b expected 00", r1, r2); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic rdy, er; logic [31:0] rd; int lat, w; int seen;
    seen = 0;
    @(negedge clk);
    req_wr = 1'b1; req_addr = 32'h20; req_wdata = 32'h55; req_funct3 = 3'b010; req_valid = 1'b1;
    @(negedge clk);                   // now in ACCESS
    req_valid = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen++;
    end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", req_ready); end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_resp: got %0d pulses expected 0", seen); end
    issue(1'b0, 32'h20, 32'h0, 3'b010, rdy, rd, er, lat, w);
    checks++; if ({er, rd} !== {1'b0, 32'h00000055}) begin errors++; $display("FAIL midreset_store_kept: got err=%b data=%h expected err=0 data=00000055", er, rd); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_merge();
    test_halfword();
    test_errors();
    test_ready_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
